// File: rtl/bus_slave_regfile_pkg.sv
// Shared encodings for the bus slave register file: transfer direction,
// FSM states and the wait-counter width.
package bus_slave_regfile_pkg;

  localparam logic READ   = 1'b1;
  localparam logic WRITE  = 1'b0;
  localparam int   WORD_W = 32;
  localparam int   CNT_W  = 4;

  typedef enum logic [1:0] {
    BUS_SLAVE_IDLE = 2'd0,
    BUS_SLAVE_WAIT = 2'd1,
    BUS_SLAVE_RESP = 2'd2
  } bus_slave_state_e;

endpackage

// File: rtl/bus_slave_mem.sv
// 1W1R register bank: synchronous write, combinational read, synchronous
// clear of every word on reset.
module bus_slave_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_slave_regfile.sv
// Bus slave endpoint: accepts a strobed request, inserts WAIT_STATES idle
// cycles, then pulses s_rdy_ low for one cycle. Define BUS_SLAVE_RO_EN to make
// word 0 a read-only ID register.
module bus_slave_regfile
  import bus_slave_regfile_pkg::*;
#(
  parameter int          ADDR_W      = 4,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h415A_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_cs_,
  input  logic              s_as_,
  input  logic              s_rw,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [WORD_W-1:0] s_wr_data,
  output logic [WORD_W-1:0] s_rd_data,
  output logic              s_rdy_
);

`ifdef BUS_SLAVE_RO_EN
  localparam logic RO_EN = 1'b1;
`else
  localparam logic RO_EN = 1'b0;
`endif

  bus_slave_state_e  r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rw;
  logic              r_guard;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rdy_;

  logic              w_accept;
  logic              w_wait_done;
  logic              w_to_resp;
  logic              w_rsp_rw;
  logic [ADDR_W-1:0] w_raddr;
  logic [WORD_W-1:0] w_mem_rdata;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_we;

  assign w_accept    = (r_state == BUS_SLAVE_IDLE) && !s_cs_ && !s_as_ && !r_guard;
  assign w_wait_done = (r_state == BUS_SLAVE_WAIT) && !s_cs_ && (r_cnt == 4'd1);
  assign w_to_resp   = (w_accept && (WAIT_STATES == 0)) || w_wait_done;

  // With zero wait states RESP follows accept directly, so read from the live bus.
  assign w_rsp_rw  = w_accept ? s_rw   : r_rw;
  assign w_raddr   = w_accept ? s_addr : r_addr;
  assign w_rd_word = (RO_EN && (w_raddr == '0)) ? ID_VALUE : w_mem_rdata;

  assign w_we = (r_state == BUS_SLAVE_RESP) && (r_rw == WRITE) &&
                !(RO_EN && (r_addr == '0));

  bus_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= BUS_SLAVE_IDLE;
      r_cnt     <= '0;
      r_rw      <= READ;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_guard   <= 1'b0;
      r_rdy_    <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_rdy_    <= !w_to_resp;
      r_rd_data <= (w_to_resp && (w_rsp_rw == READ)) ? w_rd_word : '0;
      // Masks the requester's strobe that is still low in the cycle after ready.
      r_guard   <= (r_state == BUS_SLAVE_RESP);
      case (r_state)
        BUS_SLAVE_IDLE: begin
          if (w_accept) begin
            r_rw    <= s_rw;
            r_addr  <= s_addr;
            r_wdata <= s_wr_data;
            r_cnt   <= CNT_W'(WAIT_STATES);
            r_state <= (WAIT_STATES > 0) ? BUS_SLAVE_WAIT : BUS_SLAVE_RESP;
          end
        end
        BUS_SLAVE_WAIT: begin
          if (s_cs_) begin
            r_cnt   <= '0;
            r_state <= BUS_SLAVE_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= BUS_SLAVE_RESP;
          end
        end
        BUS_SLAVE_RESP: r_state <= BUS_SLAVE_IDLE;
        default:        r_state <= BUS_SLAVE_IDLE;
      endcase
    end
  end

  assign s_rdy_    = r_rdy_;
  assign s_rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_slave_regfile.sv
// Directed bench: one slave with one wait state and one with none, sharing
// the bus signals but each selected by its own chip select.
module tb_bus_slave_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs1_ = 1'b1, cs0_ = 1'b1, as_ = 1'b1, rw = 1'b1;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd1, rd0;
  logic        rdy1_, rdy0_;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_slave_regfile #(.ADDR_W(4), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .s_cs_(cs1_), .s_as_(as_), .s_rw(rw),
    .s_addr(addr), .s_wr_data(wdata), .s_rd_data(rd1), .s_rdy_(rdy1_)
  );

  bus_slave_regfile #(.ADDR_W(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .s_cs_(cs0_), .s_as_(as_), .s_rw(rw),
    .s_addr(addr), .s_wr_data(wdata), .s_rd_data(rd0), .s_rdy_(rdy0_)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transfer; lat is the cycle count from accept edge to ready (-1 if none).
  task automatic do_xfer(input bit sel0, input logic rw_i, input logic [3:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rdv);
    lat = -1;
    rdv = '0;
    if (sel0) cs0_ = 1'b0; else cs1_ = 1'b0;
    as_ = 1'b0; rw = rw_i; addr = a; wdata = d;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if ((sel0 ? rdy0_ : rdy1_) == 1'b0) begin
        lat = i;
        rdv = sel0 ? rd0 : rd1;
      end else begin
        chk("rd_before_rdy", sel0 ? rd0 : rd1, 32'h0);
      end
    end
    tick();
    cs0_ = 1'b1; cs1_ = 1'b1; as_ = 1'b1;
    chk("rdy_after", {31'b0, sel0 ? rdy0_ : rdy1_}, 32'h1);
    chk("rd_after", sel0 ? rd0 : rd1, 32'h0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] rdv;
    int n;
    int pos [3];

    repeat (3) tick();
    chk("reset_rdy1", {31'b0, rdy1_}, 32'h1);
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rdy0", {31'b0, rdy0_}, 32'h1);
    chk("reset_rd0", rd0, 32'h0);
    reset = 1'b0;
    tick();

    // 1/2: write then read back with one wait state
    do_xfer(1'b0, 1'b0, 4'd3, 32'hCAFE_F00D, lat, rdv);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    do_xfer(1'b0, 1'b1, 4'd3, 32'h0, lat, rdv);
    chk("t2_rd_lat", 32'(lat), 32'd2);
    chk("t2_rd_data", rdv, 32'hCAFE_F00D);

    // 3: zero-wait slave returns reset value on the cycle after accept
    do_xfer(1'b1, 1'b1, 4'd5, 32'h0, lat, rdv);
    chk("t3_rd_lat", 32'(lat), 32'd1);
    chk("t3_rd_data", rdv, 32'h0);

    // 4: abort a write by raising chip select during WAIT
    cs1_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 4'd7; wdata = 32'hDEAD_BEEF;
    tick();
    cs1_ = 1'b1; as_ = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!rdy1_) n++;
    end
    chk("t4_no_rdy", 32'(n), 32'd0);
    do_xfer(1'b0, 1'b1, 4'd7, 32'h0, lat, rdv);
    chk("t4_rd_lat", 32'(lat), 32'd2);
    chk("t4_rd_data", rdv, 32'h0);

    // 5: strobe held low for 12 cycles
    n = 0;
    pos = '{0, 0, 0};
    cs1_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 4'd3;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (!rdy1_) begin
        if (n < 3) pos[n] = i;
        n++;
      end
    end
    cs1_ = 1'b1; as_ = 1'b1;
    repeat (3) tick();
    chk("t5_pulses", 32'(n), 32'd3);
    chk("t5_first", 32'(pos[0]), 32'd2);
    chk("t5_gap01", 32'(pos[1] - pos[0]), 32'd4);
    chk("t5_gap12", 32'(pos[2] - pos[1]), 32'd4);

    // 6: word 0 write then read
    do_xfer(1'b0, 1'b0, 4'd0, 32'h0000_1234, lat, rdv);
    chk("t6_wr_lat", 32'(lat), 32'd2);
    do_xfer(1'b0, 1'b1, 4'd0, 32'h0, lat, rdv);
    chk("t6_rd_lat", 32'(lat), 32'd2);
`ifdef BUS_SLAVE_RO_EN
    chk("t6_rd_data", rdv, 32'h415A_0001);
`else
    chk("t6_rd_data", rdv, 32'h0000_1234);
`endif

    // 7: reset while a write to word 9 sits in WAIT
    cs1_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 4'd9; wdata = 32'hBBBB_BBBB;
    tick();
    reset = 1'b1;
    tick();
    chk("t7_rdy_in_reset", {31'b0, rdy1_}, 32'h1);
    reset = 1'b0; cs1_ = 1'b1; as_ = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!rdy1_) n++;
    end
    chk("t7_no_rdy", 32'(n), 32'd0);
    do_xfer(1'b0, 1'b1, 4'd9, 32'h0, lat, rdv);
    chk("t7_rd_lat", 32'(lat), 32'd2);
    chk("t7_rd_data", rdv, 32'h0);
    do_xfer(1'b0, 1'b1, 4'd3, 32'h0, lat, rdv);
    chk("t7_bank_cleared", rdv, 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
